inst_ram_burst_interface: RTL and testbench
===========================================

# inst_ram_burst_interface

Instruction-side AXI read master that fills one whole I-cache line per request with a single INCR burst, replacing the single-beat fetch. It sits between the I-cache refill path and the AXI read address and read data channels. It captures `LINE_WORDS` beats into an internal line buffer, reports bus errors, and stalls the fetch stage through `cache_wait_stop_choke` until the requested word is available.

## Interface
Parameters:
- `LINE_WORDS`, default 8: words per line; power of two, 2..16.
- `ID_W`, default 4: AXI ID width.
- `AXI_ID`, default 0: value driven on ARID.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  gates launch of new requests only.
- `req_valid`  in  1  refill request.
- `req_addr`  in  32  missing PC, byte address.
- `cancel`  in  1  drops the result of the in-flight refill.
- `this_time_pc`  out  32  latched `req_addr`.
- `word_data`  out  32  instruction at `req_addr`.
- `word_valid`  out  1  one-cycle pulse, `word_data` valid.
- `line_addr`  out  32  line-aligned base address.
- `line_data`  out  32*LINE_WORDS  filled line; word i at bits [32i+31:32i].
- `line_valid`  out  1  one-cycle pulse, line complete.
- `line_err`  out  1  valid with `line_valid`: a non-OKAY RRESP or a beat-count mismatch occurred.
- `cache_wait_stop_choke`  out  1  stall to the fetch stage; high means wait.
- AR channel: `ARID` out ID_W, `ARADDR` out 32, `ARLEN` out 8, `ARSIZE` out 3, `ARBURST` out 2, `ARLOCK` out 2, `ARCACHE` out 4, `ARPROT` out 3, `ARVALID` out 1, `ARREADY` in 1.
- R channel: `RID` in ID_W, `RDATA` in 32, `RRESP` in 2, `RLAST` in 1, `RVALID` in 1, `RREADY` out 1.

## Operation
States: IDLE, AR, R, DONE.
- **IDLE:** on `req_valid & enable`, latch `this_time_pc = req_addr` and `line_addr = req_addr & ~(4*LINE_WORDS-1)`. Compute the word offset from `req_addr[2+log2(LINE_WORDS)-1:2]`. Go to AR.
- **AR:** drive `ARVALID=1`, `ARADDR=line_addr`, `ARLEN=LINE_WORDS-1`, `ARSIZE=3'b010`, `ARBURST=2'b01` (INCR), and 0 on ARLOCK, ARCACHE and ARPROT. ARVALID and all AR fields stay stable until `ARREADY`. On the handshake go to R with beat counter = 0.
- **R:** `RREADY=1`. Each `RVALID&RREADY` beat writes buffer[counter] and increments the counter, with no wrap past `LINE_WORDS-1`.
  - Any `RRESP != 2'b00` sets the sticky error flag.
  - RLAST on a beat whose counter is not `LINE_WORDS-1` also sets the error flag.
  - The state leaves R only on a beat carrying RLAST. Beats arriving after the counter is full are accepted, set the error flag, and are not written.
  - RID is not checked.
- **DONE:** one cycle. Pulse `line_valid`, present `line_err`, pulse `word_valid` with `word_data = buffer[offset]` unless already given early. Clear the error flag. Go to IDLE.
- **cancel:** sets a drop flag when asserted in AR or R. The bus transaction still runs to RLAST, because ARVALID is never withdrawn. In DONE, `line_valid` and `word_valid` are suppressed. The drop flag is cleared on leaving DONE.
- **enable low:** blocks only the IDLE→AR transition. An in-flight transaction continues.
- **cache_wait_stop_choke:** 1 in AR and R. 0 in IDLE. 0 from the cycle `word_valid` is high onward. In DONE it is 1 if a cancel is pending.

## Timing
- Reset values:
  - State IDLE.
  - ARVALID=0 and RREADY=0.
  - All AR fields 0.
  - `line_valid`, `word_valid` and `line_err` 0.
  - `this_time_pc`, `line_addr` and `word_data` 0.
  - The line buffer is not reset.
- Reset in the middle of a burst returns to IDLE. Dropping the outstanding burst is the system's responsibility, since the whole SoC resets together.
- All outputs are registered. Minimum latency with ARREADY=1 and RVALID every cycle:
  - Request sampled at edge 0.
  - ARVALID high in cycle 1.
  - RREADY high in cycle 2.
  - Beats accepted in cycles 2..LINE_WORDS+1.
  - `line_valid` in cycle LINE_WORDS+2.
- A new request is accepted only in IDLE. The earliest back-to-back relaunch is the cycle after DONE.

## Configuration
- `INST_RAM_EARLY_RESTART_EN` defined: `word_valid` pulses, and the stall drops, in the cycle after the beat whose counter equals the offset. `word_data` is taken directly from that beat. `word_valid` does not repeat in DONE. Cancel suppresses the early pulse only if `cancel` is seen before or on that beat.
- `INST_RAM_EARLY_RESTART_EN` undefined: `word_valid` coincides with `line_valid`.

## Structure
- Shared package `inst_ram_pkg`:
  - State enum.
  - AXI constants: `AXI_BURST_INCR`, `AXI_SIZE_4B`, `AXI_RESP_OKAY`.
  - `INST_LINE_WORDS_DEFAULT`.
- One sub-module, `inst_line_buffer`: LINE_WORDS×32 register array with write enable, write index and a flattened read port.

## Test plan
- LINE_WORDS=8, req_addr=0xBFC0_0014, ARREADY=1, RDATA=0x100+i per beat:
  - ARADDR=0xBFC0_0000 and ARLEN=7.
  - `line_valid` in cycle 10.
  - `word_data`=0x105 and `line_err`=0.
- ARREADY held low 5 cycles:
  - ARVALID and ARADDR stay stable throughout.
  - Handshake on cycle 6.
  - The fill then completes normally.
- RRESP=2'b10 on beat 3 → `line_err`=1 with `line_valid`. The next request gives `line_err`=0.
- RLAST on beat 5 of 8 → state returns to IDLE and `line_err`=1.
- `cancel` in R at beat 2:
  - RREADY stays high until RLAST.
  - No `line_valid`.
  - The stall stays high until IDLE.
- With the macro, offset 1 and RVALID gaps of 2 cycles → `word_valid` the cycle after beat 1, and the stall is low before `line_valid`.

Source files
------------

// File: rtl/inst_ram_pkg.sv
// Shared types and AXI constants for the instruction line-fill master.
// Optional early restart is enabled by defining INST_RAM_EARLY_RESTART_EN.
package inst_ram_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_DONE
  } ir_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int INST_LINE_WORDS_DEFAULT = 8;

  function automatic logic [31:0] line_base(
    input logic [31:0] a,
    input int          lw
  );
    return a & ~(32'(4 * lw) - 32'd1);
  endfunction

endpackage

// File: rtl/inst_line_buffer.sv
// Line storage for one refill: LINE_WORDS x 32 registers,
// single write port, whole line exposed flattened.
module inst_line_buffer #(
  parameter  int LINE_WORDS = 8,
  localparam int IW         = $clog2(LINE_WORDS)
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [IW-1:0]            i_idx,
  input  logic [31:0]              i_data,
  output logic [32*LINE_WORDS-1:0] o_line
);

  logic [31:0] r_mem [LINE_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_data;
  end

  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_rd
    assign o_line[32*g +: 32] = r_mem[g];
  end

endmodule

// File: rtl/inst_ram_burst_interface.sv
// I-cache line refill over one AXI INCR burst.
// Define INST_RAM_EARLY_RESTART_EN to release the fetch on the critical word.
module inst_ram_burst_interface
  import inst_ram_pkg::*;
#(
  parameter int             LINE_WORDS = INST_LINE_WORDS_DEFAULT,
  parameter int             ID_W       = 4,
  parameter logic [ID_W-1:0] AXI_ID    = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     req_valid,
  input  logic [31:0]              req_addr,
  input  logic                     cancel,
  output logic [31:0]              this_time_pc,
  output logic [31:0]              word_data,
  output logic                     word_valid,
  output logic [31:0]              line_addr,
  output logic [32*LINE_WORDS-1:0] line_data,
  output logic                     line_valid,
  output logic                     line_err,
  output logic                     cache_wait_stop_choke,
  output logic [ID_W-1:0]          ARID,
  output logic [31:0]              ARADDR,
  output logic [7:0]               ARLEN,
  output logic [2:0]               ARSIZE,
  output logic [1:0]               ARBURST,
  output logic [1:0]               ARLOCK,
  output logic [3:0]               ARCACHE,
  output logic [2:0]               ARPROT,
  output logic                     ARVALID,
  input  logic                     ARREADY,
  input  logic [ID_W-1:0]          RID,
  input  logic [31:0]              RDATA,
  input  logic [1:0]               RRESP,
  input  logic                     RLAST,
  input  logic                     RVALID,
  output logic                     RREADY
);

`ifdef INST_RAM_EARLY_RESTART_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam int OW = $clog2(LINE_WORDS);
  localparam int CW = OW + 1;
  localparam logic [CW-1:0] C_LAST = CW'(LINE_WORDS - 1);
  localparam logic [CW-1:0] C_FULL = CW'(LINE_WORDS);

  ir_state_e     r_state;
  logic [CW-1:0] r_cnt;
  logic [OW-1:0] r_off;
  logic          r_err;
  logic          r_drop;
  logic          r_given;

  logic w_beat;
  logic w_we;
  logic w_berr;
  logic w_drop;
  logic w_hit;
  logic [ID_W-1:0] w_rid_unused;

  assign w_rid_unused = RID;
  assign w_beat = (r_state == S_R) & RVALID & RREADY;
  assign w_we   = w_beat & (r_cnt != C_FULL);
  assign w_drop = r_drop | cancel;
  assign w_hit  = w_we & (r_cnt == {1'b0, r_off});
  // overflow beats and a premature RLAST both count as errors
  assign w_berr = (RRESP != AXI_RESP_OKAY)
                | (r_cnt == C_FULL)
                | (RLAST & (r_cnt != C_LAST));

  inst_line_buffer #(
    .LINE_WORDS(LINE_WORDS)
  ) u_buf (
    .clk   (clk),
    .i_we  (w_we),
    .i_idx (r_cnt[OW-1:0]),
    .i_data(RDATA),
    .o_line(line_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state               <= S_IDLE;
      r_cnt                 <= '0;
      r_off                 <= '0;
      r_err                 <= 1'b0;
      r_drop                <= 1'b0;
      r_given               <= 1'b0;
      this_time_pc          <= '0;
      line_addr             <= '0;
      word_data             <= '0;
      word_valid            <= 1'b0;
      line_valid            <= 1'b0;
      line_err              <= 1'b0;
      cache_wait_stop_choke <= 1'b0;
      ARID                  <= '0;
      ARADDR                <= '0;
      ARLEN                 <= '0;
      ARSIZE                <= '0;
      ARBURST               <= '0;
      ARLOCK                <= '0;
      ARCACHE               <= '0;
      ARPROT                <= '0;
      ARVALID               <= 1'b0;
      RREADY                <= 1'b0;
    end else begin
      line_valid <= 1'b0;
      word_valid <= 1'b0;
      line_err   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (req_valid & enable) begin
            this_time_pc          <= req_addr;
            line_addr             <= line_base(req_addr, LINE_WORDS);
            r_off                 <= req_addr[OW+1:2];
            ARID                  <= AXI_ID;
            ARADDR                <= line_base(req_addr, LINE_WORDS);
            ARLEN                 <= 8'(LINE_WORDS - 1);
            ARSIZE                <= AXI_SIZE_4B;
            ARBURST               <= AXI_BURST_INCR;
            ARLOCK                <= '0;
            ARCACHE               <= '0;
            ARPROT                <= '0;
            ARVALID               <= 1'b1;
            cache_wait_stop_choke <= 1'b1;
            r_state               <= S_AR;
          end
        end
        S_AR: begin
          if (cancel) r_drop <= 1'b1;
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_R;
          end
        end
        S_R: begin
          if (cancel) r_drop <= 1'b1;
          if (w_beat) begin
            if (w_berr) r_err <= 1'b1;
            if (r_cnt != C_FULL) r_cnt <= r_cnt + CW'(1);
            if (w_hit) begin
              word_data <= RDATA;
              if (EARLY && !w_drop) begin
                word_valid            <= 1'b1;
                cache_wait_stop_choke <= 1'b0;
                r_given               <= 1'b1;
              end
            end
            if (RLAST) begin
              RREADY                <= 1'b0;
              line_valid            <= ~w_drop;
              line_err              <= (r_err | w_berr) & ~w_drop;
              cache_wait_stop_choke <= w_drop & ~r_given;
              if (!EARLY) word_valid <= ~w_drop;
              r_state               <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_err                 <= 1'b0;
          r_drop                <= 1'b0;
          r_given               <= 1'b0;
          cache_wait_stop_choke <= 1'b0;
          r_state               <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_ram_burst_interface.sv
// Directed bench for the I-cache burst refill master.
// Expected lines are queued at request time and popped on line_valid.
module tb_inst_ram_burst_interface;

`ifdef INST_RAM_EARLY_RESTART_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            req_valid;
  logic [31:0]     req_addr;
  logic            cancel;
  logic [31:0]     this_time_pc;
  logic [31:0]     word_data;
  logic            word_valid;
  logic [31:0]     line_addr;
  logic [32*LW-1:0] line_data;
  logic            line_valid;
  logic            line_err;
  logic            stall;
  logic [3:0]      ARID;
  logic [31:0]     ARADDR;
  logic [7:0]      ARLEN;
  logic [2:0]      ARSIZE;
  logic [1:0]      ARBURST;
  logic [1:0]      ARLOCK;
  logic [3:0]      ARCACHE;
  logic [2:0]      ARPROT;
  logic            ARVALID;
  logic            ARREADY;
  logic [3:0]      RID;
  logic [31:0]     RDATA;
  logic [1:0]      RRESP;
  logic            RLAST;
  logic            RVALID;
  logic            RREADY;

  inst_ram_burst_interface #(
    .LINE_WORDS(LW),
    .ID_W      (4),
    .AXI_ID    (4'h0)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .enable               (enable),
    .req_valid            (req_valid),
    .req_addr             (req_addr),
    .cancel               (cancel),
    .this_time_pc         (this_time_pc),
    .word_data            (word_data),
    .word_valid           (word_valid),
    .line_addr            (line_addr),
    .line_data            (line_data),
    .line_valid           (line_valid),
    .line_err             (line_err),
    .cache_wait_stop_choke(stall),
    .ARID                 (ARID),
    .ARADDR               (ARADDR),
    .ARLEN                (ARLEN),
    .ARSIZE               (ARSIZE),
    .ARBURST              (ARBURST),
    .ARLOCK               (ARLOCK),
    .ARCACHE              (ARCACHE),
    .ARPROT               (ARPROT),
    .ARVALID              (ARVALID),
    .ARREADY              (ARREADY),
    .RID                  (RID),
    .RDATA                (RDATA),
    .RRESP                (RRESP),
    .RLAST                (RLAST),
    .RVALID               (RVALID),
    .RREADY               (RREADY)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] base;
    logic        err;
    int          nb;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [31:0] addr, input logic [31:0] base,
                      input int ar_wait, input int nb, input int err_beat,
                      input int cancel_beat, input int gap);
    int   off;
    int   c0;
    bit   exp_line;
    bit   canc;
    exp_t e;
    logic [31:0] a;
    off      = int'(addr[4:2]);
    exp_line = (cancel_beat < 0);
    canc     = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    enable    = 1'b1;
    if (exp_line) begin
      e.addr = addr;
      e.base = base;
      e.err  = (err_beat >= 0 && err_beat < nb) || (nb != LW);
      e.nb   = nb;
      exp_q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
    c0 = cyc;
    chk("this_pc", this_time_pc, addr);
    for (int w = 0; w <= ar_wait; w++) begin
      chkb("arvalid", ARVALID, 1'b1);
      chk("araddr", ARADDR, addr & 32'hFFFF_FFE0);
      chkb("stall_ar", stall, 1'b1);
      if (w == 0) begin
        chk("arlen", 32'(ARLEN), 32'd7);
        chk("arsize_burst", {27'd0, ARSIZE, ARBURST}, 32'b01001);
      end
      ARREADY = (w == ar_wait);
      @(negedge clk);
    end
    ARREADY = 1'b0;
    chkb("arvalid_drop", ARVALID, 1'b0);
    for (int b = 0; b < nb; b++) begin
      repeat (gap) begin
        chkb("rready_gap", RREADY, 1'b1);
        @(negedge clk);
      end
      chkb("rready", RREADY, 1'b1);
      RVALID = 1'b1;
      RDATA  = base + 32'(b);
      RRESP  = (b == err_beat) ? 2'b10 : 2'b00;
      RLAST  = (b == nb - 1);
      cancel = (b == cancel_beat);
      if (b == cancel_beat) canc = 1'b1;
      @(negedge clk);
      RVALID = 1'b0;
      RLAST  = 1'b0;
      RRESP  = 2'b00;
      cancel = 1'b0;
      if (b == off) begin
        chkb("wv_after_hit", word_valid,
             !canc && (EARLY || b == nb - 1));
        if (EARLY && !canc) begin
          chk("early_wdata", word_data, base + 32'(off));
          chkb("early_stall", stall, 1'b0);
        end
      end
    end
    chk("done_cycle", 32'(cyc - c0 + 1),
        32'(2 + ar_wait + nb * (gap + 1)));
    chkb("line_valid", line_valid, exp_line);
    chkb("wv_done", word_valid, exp_line && (!EARLY || off == nb - 1));
    chkb("stall_done", stall, !exp_line);
    if (line_valid) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = e.addr & 32'hFFFF_FFE0;
        chk("line_addr", line_addr, a);
        chkb("line_err", line_err, e.err);
        if (off < e.nb) chk("word_data", word_data, e.base + 32'(off));
        for (int i = 0; i < e.nb; i++)
          chk("line_word", line_data[32*i +: 32], e.base + 32'(i));
      end else begin
        n_chk++;
        n_err++;
        $error("FAIL sb_empty observed=line_valid expected=none");
      end
    end
    @(negedge clk);
    chkb("stall_idle", stall, 1'b0);
    chkb("rready_idle", RREADY, 1'b0);
    chkb("lv_clear", line_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    cancel    = 1'b0;
    ARREADY   = 1'b0;
    RID       = '0;
    RDATA     = '0;
    RRESP     = '0;
    RLAST     = 1'b0;
    RVALID    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chkb("rst_arvalid", ARVALID, 1'b0);
    chkb("rst_rready", RREADY, 1'b0);
    chkb("rst_lv", line_valid, 1'b0);
    chkb("rst_wv", word_valid, 1'b0);
    chkb("rst_lerr", line_err, 1'b0);
    chkb("rst_stall", stall, 1'b0);
    chk("rst_pc", this_time_pc, 32'd0);
    chk("rst_laddr", line_addr, 32'd0);
    chk("rst_wdata", word_data, 32'd0);
    chk("rst_araddr", ARADDR, 32'd0);
    chk("rst_arlen", 32'(ARLEN), 32'd0);

    req_valid = 1'b1;
    req_addr  = 32'h1234_0000;
    enable    = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chkb("en_low_arvalid", ARVALID, 1'b0);
      chkb("en_low_stall", stall, 1'b0);
    end
    req_valid = 1'b0;

    fill(32'hBFC0_0014, 32'h100, 0, 8, -1, -1, 0);
    fill(32'h0000_1008, 32'h200, 5, 8, -1, -1, 0);
    fill(32'h4000_0020, 32'h300, 0, 8, 3, -1, 0);
    fill(32'h4000_0044, 32'h400, 0, 8, -1, -1, 0);
    fill(32'h8000_0040, 32'h500, 0, 5, -1, -1, 0);
    fill(32'hA000_0018, 32'h600, 0, 8, -1, 2, 0);
    fill(32'hA000_0024, 32'h700, 1, 8, -1, -1, 0);
    fill(32'hC000_0004, 32'h800, 0, 8, -1, -1, 2);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
